// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the Olivia LEGv8 core.
// Sequences the shared datapath through FETCH, DECODE, EXEC, MEM and WB.
// Instruction and data memories use ready handshakes, so wait states simply
// stretch FETCH and MEM. An illegal opcode parks the core in HALT until reset.
// Cycle and retired-instruction counters are provided for the bench.
module multicycle_ctrl #(
    parameter int OPCODE_W = 11,
    parameter int CNT_W    = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ir_is_zero,
    input  logic                zero_flag,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic [2:0]          state,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg2loc,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                halted,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instr_retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_LD, C_ST, C_CBZ, C_B, C_NOP, C_ILL
    } iclass_t;

    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(11'b10001011000);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(11'b11001011000);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(11'b10001010000);
    localparam logic [OPCODE_W-1:0] OP_ORR  = OPCODE_W'(11'b10101010000);
    localparam logic [OPCODE_W-1:0] OP_LDUR = OPCODE_W'(11'b11111000010);
    localparam logic [OPCODE_W-1:0] OP_STUR = OPCODE_W'(11'b11111000000);
    localparam logic [OPCODE_W-1:0] OP_CBZ  = OPCODE_W'(11'b10110100000);
    localparam logic [OPCODE_W-1:0] OP_B    = OPCODE_W'(11'b00010100000);

    state_t          state_q, state_d;
    iclass_t         dec_class, cls_q;
    logic            retire;
    logic [CNT_W-1:0] cycle_q, retired_q;

    // Classify the instruction register contents (valid while in DECODE).
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        dec_class = C_ILL;
        if (ir_is_zero) begin
            dec_class = C_NOP;
        end else begin
            case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_ORR: dec_class = C_R;
                OP_LDUR:                        dec_class = C_LD;
                OP_STUR:                        dec_class = C_ST;
                OP_CBZ:                         dec_class = C_CBZ;
                OP_B:                           dec_class = C_B;
                default:                        dec_class = C_ILL;
            endcase
        end
    end

    // State register, latched instruction class and counters; reset is synchronous.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!RST) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NOP;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cls_q <= dec_class;
            if (state_q != S_HALT) cycle_q <= cycle_q + 1'b1;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    // Next-state and strobe decode; strobes follow the current state.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                reg2loc = (dec_class == C_ST) || (dec_class == C_CBZ);
                case (dec_class)
                    C_NOP: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    C_ILL:   state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_LD, C_ST: begin
                        alu_src = 1'b1;
                        reg2loc = (cls_q == C_ST);
                        state_d = S_MEM;
                    end
                    C_CBZ: begin
                        alu_op   = 2'b01;
                        reg2loc  = 1'b1;
                        pc_src   = 2'b01;
                        pc_write = zero_flag;
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                    end
                    C_B: begin
                        pc_src   = 2'b10;
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                        retire   = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                // Address path stays steady until the memory completes.
                alu_src    = 1'b1;
                reg2loc    = (cls_q == C_ST);
                dmem_read  = (cls_q == C_LD);
                dmem_write = (cls_q == C_ST);
                if (dmem_ready) begin
                    if (cls_q == C_LD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LD);
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    assign state         = state_q;
    assign halted        = (state_q == S_HALT);
    assign cycle_count   = cycle_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction plan of expected
// cycles is expanded from the class latency rules and played against the DUT
// with randomized wait states and don't-care inputs.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [10:0]      opcode = '0;
    logic             ir_is_zero = 1'b0, zero_flag = 1'b0;
    logic             imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [2:0]       state;
    logic             imem_req, ir_write, pc_write, reg2loc, alu_src;
    logic [1:0]       pc_src, alu_op;
    logic             dmem_read, dmem_write, mem_to_reg, reg_write, halted;
    logic [CNT_W-1:0] cycle_count, instr_retired;

    multicycle_ctrl #(.OPCODE_W(11), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .ir_is_zero(ir_is_zero),
        .zero_flag(zero_flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .state(state), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .halted(halted), .cycle_count(cycle_count),
        .instr_retired(instr_retired)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       imem_req, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       reg2loc, alu_src;
        logic [1:0] alu_op;
        logic       dmem_read, dmem_write, mem_to_reg, reg_write, halted;
    } ctl_t;

    typedef struct {
        logic [2:0] st;
        ctl_t       ctl;
        ctl_t       care;
        logic       imem_rdy;
        logic       dmem_rdy;
        logic       retire;
    } cyc_t;

    typedef enum int { K_R, K_LD, K_ST, K_CBZ, K_B, K_NOP, K_ILL } kind_t;

    ctl_t obs;
    assign obs = {imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
                  dmem_read, dmem_write, mem_to_reg, reg_write, halted};

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned exp_cyc = 0;
    int unsigned exp_ret = 0;
    cyc_t        plan[$];
    logic [10:0] cur_op;
    logic        cur_nop, cur_zf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    // Fresh cycle record: all strobes expected 0; pc_src, reg2loc and ALU
    // controls are don't-care unless a phase says otherwise.
    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c.st           = st;
        c.ctl          = '0;
        c.care         = '1;
        c.care.pc_src  = 2'b00;
        c.care.reg2loc = 1'b0;
        c.care.alu_src = 1'b0;
        c.care.alu_op  = 2'b00;
        c.imem_rdy     = 1'($urandom);
        c.dmem_rdy     = 1'($urandom);
        c.retire       = 1'b0;
        return c;
    endfunction

    function automatic logic [10:0] op_for(input kind_t k);
        logic [10:0] r_ops [4];
        logic [10:0] o;
        r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        case (k)
            K_R:   o = r_ops[$urandom_range(3)];
            K_LD:  o = 11'b11111000010;
            K_ST:  o = 11'b11111000000;
            K_CBZ: o = 11'b10110100000;
            K_B:   o = 11'b00010100000;
            K_NOP: o = 11'b0;
            default: begin
                o = 11'b11111111111;
                if ($urandom_range(1) == 1) begin
                    do o = 11'($urandom);
                    while (o inside {11'b10001011000, 11'b11001011000, 11'b10001010000,
                                     11'b10101010000, 11'b11111000010, 11'b11111000000,
                                     11'b10110100000, 11'b00010100000});
                end
            end
        endcase
        return o;
    endfunction

    // Expand one instruction into its expected cycles from the latency rules.
    task automatic build(input kind_t k, input int iw, input int dw, input logic zf);
        cyc_t c;
        cur_op  = op_for(k);
        cur_nop = (k == K_NOP);
        cur_zf  = zf;
        for (int i = 0; i < iw; i++) begin
            c = mk(3'd0);
            c.ctl.imem_req = 1'b1;
            c.imem_rdy     = 1'b0;
            plan.push_back(c);
        end
        c = mk(3'd0);
        c.ctl.imem_req = 1'b1;
        c.ctl.ir_write = 1'b1;
        c.ctl.pc_write = 1'b1;
        c.care.pc_src  = 2'b11;
        c.imem_rdy     = 1'b1;
        plan.push_back(c);
        c = mk(3'd1);
        c.care.reg2loc = 1'b1;
        c.ctl.reg2loc  = (k == K_ST) || (k == K_CBZ);
        c.retire       = (k == K_NOP);
        plan.push_back(c);
        if (k == K_NOP || k == K_ILL) return;
        c = mk(3'd2);
        case (k)
            K_R: begin
                c.care.alu_op = 2'b11; c.care.alu_src = 1'b1;
                c.ctl.alu_op  = 2'b10; c.ctl.alu_src  = 1'b0;
            end
            K_LD, K_ST: begin
                c.care.alu_op = 2'b11; c.care.alu_src = 1'b1;
                c.ctl.alu_op  = 2'b00; c.ctl.alu_src  = 1'b1;
            end
            K_CBZ: begin
                c.care.alu_op  = 2'b11; c.ctl.alu_op  = 2'b01;
                c.care.reg2loc = 1'b1;  c.ctl.reg2loc = 1'b1;
                c.ctl.pc_write = zf;
                if (zf) begin c.care.pc_src = 2'b11; c.ctl.pc_src = 2'b01; end
                c.retire = 1'b1;
            end
            default: begin
                c.ctl.pc_write = 1'b1;
                c.care.pc_src  = 2'b11; c.ctl.pc_src = 2'b10;
                c.retire       = 1'b1;
            end
        endcase
        plan.push_back(c);
        if (k == K_LD || k == K_ST) begin
            for (int j = 0; j <= dw; j++) begin
                c = mk(3'd3);
                c.care.alu_op  = 2'b11; c.care.alu_src = 1'b1;
                c.ctl.alu_op   = 2'b00; c.ctl.alu_src  = 1'b1;
                c.ctl.dmem_read  = (k == K_LD);
                c.ctl.dmem_write = (k == K_ST);
                c.dmem_rdy       = (j == dw);
                c.retire         = (k == K_ST) && (j == dw);
                plan.push_back(c);
            end
        end
        if (k == K_R || k == K_LD) begin
            c = mk(3'd4);
            c.ctl.reg_write  = 1'b1;
            c.ctl.mem_to_reg = (k == K_LD);
            c.retire         = 1'b1;
            plan.push_back(c);
        end
    endtask

    // Play up to n planned cycles (all if n < 0); entered and left just after a negedge.
    task automatic play(input int n);
        cyc_t c;
        int   cnt = 0;
        while (plan.size() > 0 && (n < 0 || cnt < n)) begin
            c = plan.pop_front();
            imem_ready = c.imem_rdy;
            dmem_ready = c.dmem_rdy;
            zero_flag  = (c.st == 3'd2) ? cur_zf : 1'($urandom);
            if (c.st == 3'd0) begin
                opcode = 11'($urandom); ir_is_zero = 1'($urandom);
            end else begin
                opcode = cur_op; ir_is_zero = cur_nop;
            end
            #1;
            check("state", 64'(state), 64'(c.st));
            check("ctl", 64'(obs & c.care), 64'(c.ctl & c.care));
            check("cycle_count", 64'(cycle_count), 64'(exp_cyc));
            check("instr_retired", 64'(instr_retired), 64'(exp_ret));
            @(posedge CLK);
            exp_cyc++;
            if (c.retire) exp_ret++;
            @(negedge CLK);
            cnt++;
        end
        plan.delete();
    endtask

    task automatic do_reset(input int n);
        RST = 1'b0;
        repeat (n) @(negedge CLK);
        RST = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    task automatic run(input kind_t k, input int iw, input int dw, input logic zf);
        build(k, iw, dw, zf);
        play(-1);
    endtask

    initial begin
        @(negedge CLK);
        do_reset(2);

        // Directed sequences from the plan.
        run(K_R, 0, 0, 1'b0);
        run(K_LD, 0, 3, 1'b0);
        run(K_ST, 0, 0, 1'b0);
        run(K_CBZ, 0, 0, 1'b1);
        run(K_CBZ, 0, 0, 1'b0);
        run(K_B, 0, 0, 1'b0);
        run(K_NOP, 0, 0, 1'b0);

        // Randomized instruction mix with random wait states.
        for (int i = 0; i < 80; i++) begin
            run(kind_t'($urandom_range(5)), $urandom_range(3), $urandom_range(3),
                1'($urandom));
        end

        // Illegal opcode: DECODE then sticky HALT with frozen counters.
        run(K_ILL, $urandom_range(2), 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            zero_flag  = 1'($urandom); opcode = 11'($urandom); ir_is_zero = 1'($urandom);
            #1;
            check("halt_state", 64'(state), 64'd7);
            check("halt_ctl", 64'(obs), 64'(ctl_t'(14'b1)));
            check("halt_cycles", 64'(cycle_count), 64'(exp_cyc));
            check("halt_retired", 64'(instr_retired), 64'(exp_ret));
            @(negedge CLK);
        end
        do_reset(1);

        // Fetch stalled 5 cycles, then NOP; then reset during an LDUR MEM wait.
        run(K_NOP, 5, 0, 1'b0);
        build(K_LD, 0, 3, 1'b0);
        play(4);
        RST = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("pre_reset_dmem_read", 64'(dmem_read), 64'd1);
        @(posedge CLK);
        #1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_dmem_read", 64'(dmem_read), 64'd0);
        check("reset_cycles", 64'(cycle_count), 64'd0);
        check("reset_retired", 64'(instr_retired), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;

        // Machine runs normally after the abandoned access.
        run(K_LD, 1, 1, 1'b0);
        run(K_R, 0, 0, 1'b0);
        run(K_CBZ, 2, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
